// File: rtl/num_serializer.sv
// num_serializer
//
// Shifts the low L significant bits of a captured 64-bit number out
// MSB-first as a 1-bit stream. L = min(len_in, 64), where len_in comes from
// the upstream bit-length stage. A word starts on md_start (only honoured in
// IDLE) and finishes with a one-cycle md_end pulse.
//
// Optional feature, selected by the macro NUM_SERIALIZER_GAMMA_EN:
//   defined   - Elias-gamma framing: L-1 zero prefix bits, then the L data
//               bits (2L-1 bits per word; L=1 has no prefix).
//   undefined - exactly L data bits per word; no PREFIX state is built.
//
// Handshake (bit_valid / bit_ready):
//   A bit transfers on a rising edge where bit_valid && bit_ready. While
//   bit_valid is high and bit_ready is low, bit_out / bit_valid / bit_last
//   hold their values. bit_valid never drops before its bit transfers.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   md_start   start request, sampled only in IDLE
//   num_in     number to serialize, captured on accepted md_start
//   len_in     significant bit count, captured with num_in (clamped to 64)
//   bit_ready  downstream accepts bit_out this cycle
//   bit_out    current serial bit (registered)
//   bit_valid  bit_out is valid (registered)
//   bit_last   current bit is the last bit of the word (registered)
//   busy       high in every state except IDLE (registered)
//   md_end     one-cycle done pulse (registered)

module num_serializer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        md_start,
    input  logic [63:0] num_in,
    input  logic [7:0]  len_in,
    input  logic        bit_ready,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        bit_last,
    output logic        busy,
    output logic        md_end
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        DONE   = 2'd2
`ifdef NUM_SERIALIZER_GAMMA_EN
        ,
        PREFIX = 2'd3
`endif
    } state_t;

    state_t      state;
    // Holds the bits still to be presented after the one on bit_out,
    // left-aligned so the next bit is always at [63].
    logic [63:0] shreg;
    // Data bits remaining, counting the one currently on bit_out.
    logic [6:0]  rem;
`ifdef NUM_SERIALIZER_GAMMA_EN
    // Prefix zeros remaining, counting the one currently on bit_out.
    logic [6:0]  pre_cnt;
`endif

    logic [6:0]  eff_len;
    logic [63:0] aligned;
    logic        xfer;

    assign eff_len = (len_in > 8'd64) ? 7'd64 : len_in[6:0];
    // Move bit L-1 up to bit 63 so everything above it falls off the top.
    // For L=0 the shift is 64 and the result is all zeros (unused anyway).
    assign aligned = num_in << (7'd64 - eff_len);
    assign xfer    = bit_valid & bit_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            shreg     <= '0;
            rem       <= '0;
`ifdef NUM_SERIALIZER_GAMMA_EN
            pre_cnt   <= '0;
`endif
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
            busy      <= 1'b0;
            md_end    <= 1'b0;
        end else begin
            md_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (md_start) begin
                        rem   <= eff_len;
                        busy  <= 1'b1;
                        shreg <= {aligned[62:0], 1'b0};
                        if (eff_len == 7'd0) begin
                            state  <= DONE;
                            md_end <= 1'b1;
                        end
`ifdef NUM_SERIALIZER_GAMMA_EN
                        else if (eff_len > 7'd1) begin
                            // Data bits are not on bit_out yet, so keep the
                            // whole aligned word in the shift register.
                            state     <= PREFIX;
                            shreg     <= aligned;
                            pre_cnt   <= eff_len - 7'd1;
                            bit_out   <= 1'b0;
                            bit_valid <= 1'b1;
                            bit_last  <= 1'b0;
                        end
`endif
                        else begin
                            state     <= DATA;
                            bit_out   <= aligned[63];
                            bit_valid <= 1'b1;
                            bit_last  <= (eff_len == 7'd1);
                        end
                    end
                end

`ifdef NUM_SERIALIZER_GAMMA_EN
                PREFIX: begin
                    if (xfer) begin
                        if (pre_cnt == 7'd1) begin
                            // L >= 2 here, so the first data bit is never last.
                            state    <= DATA;
                            bit_out  <= shreg[63];
                            shreg    <= {shreg[62:0], 1'b0};
                            bit_last <= 1'b0;
                        end else begin
                            pre_cnt <= pre_cnt - 7'd1;
                        end
                    end
                end
`endif

                DATA: begin
                    if (xfer) begin
                        if (rem == 7'd1) begin
                            state     <= DONE;
                            bit_out   <= 1'b0;
                            bit_valid <= 1'b0;
                            bit_last  <= 1'b0;
                            md_end    <= 1'b1;
                        end else begin
                            rem      <= rem - 7'd1;
                            bit_out  <= shreg[63];
                            shreg    <= {shreg[62:0], 1'b0};
                            bit_last <= (rem == 7'd2);
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    bit_out   <= 1'b0;
                    bit_valid <= 1'b0;
                    bit_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_num_serializer.sv
// Directed testbench for num_serializer. Expected streams are written out
// by hand per word; cycle numbers are counted from the accepting edge.

module tb_num_serializer;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rstn;
  logic        md_start;
  logic [63:0] num_in;
  logic [7:0]  len_in;
  logic        bit_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_last;
  logic        busy;
  logic        md_end;

  always #5 clk = ~clk;

  num_serializer dut (
    .clk       (clk),
    .rstn      (rstn),
    .md_start  (md_start),
    .num_in    (num_in),
    .len_in    (len_in),
    .bit_ready (bit_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .busy      (busy),
    .md_end    (md_end)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [0:0] exp_q[$];

  task automatic fail(input string name, input int idx,
                      input logic [63:0] obs, input logic [63:0] exp);
    errors++;
    $error("FAIL %s[%0d]: observed %0h expected %0h", name, idx, obs, exp);
  endtask

  // Push a hand-written stream of len bits (MSB first). The gamma build
  // expects len-1 leading zeros in front of it.
  task automatic push_stream(input int len, input logic [63:0] bits);
`ifdef NUM_SERIALIZER_GAMMA_EN
    for (int i = 1; i < len; i++) exp_q.push_back(1'b0);
`endif
    for (int i = len - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  // Cycle (counted from the accepting edge) in which md_end is expected.
  function automatic int end_cyc(input int len, input int stall);
    if (len == 0) return 1;
`ifdef NUM_SERIALIZER_GAMMA_EN
    return 2 * len + stall;
`else
    return len + 1 + stall;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of cycle 1 of the word,
  // with the captured inputs scrambled to show they no longer matter.
  task automatic send_word(input logic [63:0] num, input logic [7:0] len);
    md_start = 1'b1;
    num_in   = num;
    len_in   = len;
    @(posedge clk);
    @(negedge clk);
    md_start = 1'b0;
    num_in   = {$urandom, $urandom};
    len_in   = 8'($urandom_range(0, 255));
  endtask

  // Walk the word cycle by cycle against exp_q. bit_ready is low in
  // cycles [stall_from, stall_from+stall_len); md_start is pulsed in cycle
  // poke_cyc (must be ignored). Returns at the negedge of the first IDLE
  // cycle after md_end.
  task automatic collect(input string tag, input int exp_end,
                         input int stall_from, input int stall_len,
                         input int poke_cyc);
    int idx;
    int n;
    int cyc;
    idx = 0;
    n   = exp_q.size();
    cyc = 1;
    while (idx < n && cyc < 400) begin
      bit_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      md_start  = (cyc == poke_cyc);
      num_in    = {$urandom, $urandom};
      len_in    = 8'($urandom_range(0, 255));
      checks++;
      if (bit_valid !== 1'b1) fail({tag, "_valid"}, cyc, bit_valid, 1'b1);
      checks++;
      if (bit_out !== exp_q[idx]) fail({tag, "_bit"}, idx, bit_out, exp_q[idx]);
      checks++;
      if (bit_last !== (idx == n - 1)) fail({tag, "_last"}, idx, bit_last, (idx == n - 1));
      checks++;
      if (busy !== 1'b1) fail({tag, "_busy"}, cyc, busy, 1'b1);
      checks++;
      if (md_end !== 1'b0) fail({tag, "_early_end"}, cyc, md_end, 1'b0);
      if (bit_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    md_start  = 1'b0;
    bit_ready = 1'b1;
    checks++;
    if (md_end !== 1'b1) fail({tag, "_end"}, cyc, md_end, 1'b1);
    checks++;
    if (cyc != exp_end) fail({tag, "_end_cycle"}, 0, cyc, exp_end);
    checks++;
    if (bit_valid !== 1'b0) fail({tag, "_end_valid"}, cyc, bit_valid, 1'b0);
    checks++;
    if (busy !== 1'b1) fail({tag, "_end_busy"}, cyc, busy, 1'b1);
    @(negedge clk);
    checks++;
    if (md_end !== 1'b0) fail({tag, "_idle_end"}, cyc + 1, md_end, 1'b0);
    checks++;
    if (busy !== 1'b0) fail({tag, "_idle_busy"}, cyc + 1, busy, 1'b0);
    checks++;
    if (bit_valid !== 1'b0) fail({tag, "_idle_valid"}, cyc + 1, bit_valid, 1'b0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn      = 1'b0;
    md_start  = 1'b0;
    num_in    = '0;
    len_in    = '0;
    bit_ready = 1'b1;

    repeat (2) @(negedge clk);
    checks++;
    if (bit_out !== 1'b0) fail("rst_out", 0, bit_out, 1'b0);
    checks++;
    if (bit_valid !== 1'b0) fail("rst_valid", 0, bit_valid, 1'b0);
    checks++;
    if (bit_last !== 1'b0) fail("rst_last", 0, bit_last, 1'b0);
    checks++;
    if (busy !== 1'b0) fail("rst_busy", 0, busy, 1'b0);
    checks++;
    if (md_end !== 1'b0) fail("rst_end", 0, md_end, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    // 255, L=8: eight ones
    push_stream(8, 64'hFF);
    send_word(64'd255, 8'd8);
    collect("w255", end_cyc(8, 0), 0, 0, 0);

    // 0x3FF, L=10 with an ignored md_start mid-word, then 5, L=3 back-to-back
    push_stream(10, 64'h3FF);
    send_word(64'h3FF, 8'd10);
    collect("w3ff", end_cyc(10, 0), 0, 0, 3);
    push_stream(3, 64'h5);
    send_word(64'd5, 8'd3);
    collect("w5", end_cyc(3, 0), 0, 0, 0);

    // L=0: no bits, md_end in cycle 1
    send_word(64'd0, 8'd0);
    collect("zero", end_cyc(0, 0), 0, 0, 0);

    // garbage above bit L-1 is ignored: 0xF0D, L=3 -> 1,0,1
    push_stream(3, 64'h5);
    send_word(64'hF0D, 8'd3);
    collect("hi_ign", end_cyc(3, 0), 0, 0, 0);

    // backpressure: 110, bit_ready low in cycles 2 and 3
    push_stream(3, 64'h6);
    send_word(64'h6, 8'd3);
    collect("bp", end_cyc(3, 2), 2, 2, 0);

    // clamp: len 200 -> exactly 64 ones
    push_stream(64, 64'hFFFF_FFFF_FFFF_FFFF);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 8'd200);
    collect("clamp", end_cyc(64, 0), 0, 0, 0);

    // reset mid-word after 10 bits
    push_stream(64, 64'hFFFF_FFFF_FFFF_FFFF);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 8'd200);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bit_valid !== 1'b1) fail("mid_valid", k, bit_valid, 1'b1);
      checks++;
      if (bit_out !== exp_q[k]) fail("mid_bit", k, bit_out, exp_q[k]);
      @(negedge clk);
    end
    exp_q.delete();
    rstn = 1'b0;
    #1;
    checks++;
    if (bit_out !== 1'b0) fail("mrst_out", 0, bit_out, 1'b0);
    checks++;
    if (bit_valid !== 1'b0) fail("mrst_valid", 0, bit_valid, 1'b0);
    checks++;
    if (bit_last !== 1'b0) fail("mrst_last", 0, bit_last, 1'b0);
    checks++;
    if (busy !== 1'b0) fail("mrst_busy", 0, busy, 1'b0);
    checks++;
    if (md_end !== 1'b0) fail("mrst_end", 0, md_end, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (md_end !== 1'b0) fail("post_rst_end", k, md_end, 1'b0);
      checks++;
      if (bit_valid !== 1'b0) fail("post_rst_valid", k, bit_valid, 1'b0);
      checks++;
      if (busy !== 1'b0) fail("post_rst_busy", k, busy, 1'b0);
    end

    // normal word after reset release
    push_stream(3, 64'h5);
    send_word(64'd5, 8'd3);
    collect("after_rst", end_cyc(3, 0), 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

endmodule
